// File: rtl/int_req_gen_pkg.sv
// Shared types and constants for the PC-triggered interrupt source.
// Macro INT_REQ_GEN_TIMEOUT_EN (see int_req_gen.sv) enables the acknowledge deadline.
package int_req_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ASSERT = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7f20;
    localparam logic [31:0] WORD_MASK        = 32'hffff_fffc;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/int_trig_table.sv
// Trigger-PC register file: synchronous write, combinational read at the current index.
// hit_o compares the word-aligned PC against the selected entry.
module int_trig_table
    import int_req_gen_pkg::*;
#(
    parameter  int TRIG_DEPTH = 8,
    localparam int IW         = $clog2(TRIG_DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  logic [31:0]   wpc_i,
    input  logic [IW-1:0] ridx_i,
    input  logic [31:0]   pc_i,
    output logic          hit_o
);

    // Only the word address is kept; the two byte-offset bits are dropped on write.
    logic [29:0] trig_q [TRIG_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            trig_q[widx_i] <= 30'(word_addr(wpc_i) >> 2);
        end
    end

    assign hit_o = ({trig_q[ridx_i], 2'b00} == word_addr(pc_i));

endmodule

// File: rtl/int_req_gen.sv
// PC-triggered external interrupt source with store-to-address acknowledge handshake.
// Define INT_REQ_GEN_TIMEOUT_EN to build the acknowledge deadline counter and timeout_err.
module int_req_gen
    import int_req_gen_pkg::*;
#(
    parameter  logic [31:0] ACK_ADDR       = ACK_ADDR_DEFAULT,
    parameter  int          TRIG_DEPTH     = 8,
    parameter  int          TIMEOUT_CYCLES = 1024,
    localparam int          IW             = $clog2(TRIG_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   macroscopic_pc,
    input  logic [31:0]   m_int_addr,
    input  logic [3:0]    m_int_byteen,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [31:0]   cfg_pc,
    input  logic          arm,
    input  logic [IW:0]   arm_num,
    input  logic          abort,
    output logic          interrupt,
    output logic          busy,
    output logic          done,
    output logic [15:0]   int_count,
    output logic          timeout_err
);

    localparam logic [IW:0] DEPTH_N = (IW + 1)'(TRIG_DEPTH);
    localparam logic [IW:0] IDX_ONE = (IW + 1)'(1);

    state_e      state_q, state_d;
    logic [IW:0] idx_q, idx_d;
    logic [IW:0] num_q, num_d;
    logic [15:0] cnt_q, cnt_d;
    logic        int_q;
    logic        hit, ack, tmo, arm_ok;

    int_trig_table #(.TRIG_DEPTH(TRIG_DEPTH)) u_table (
        .clk    (clk),
        .we_i   (cfg_we && state_q == IDLE),
        .widx_i (cfg_idx),
        .wpc_i  (cfg_pc),
        .ridx_i (idx_q[IW-1:0]),
        .pc_i   (macroscopic_pc),
        .hit_o  (hit)
    );

    assign ack    = (|m_int_byteen) && (word_addr(m_int_addr) == ACK_ADDR);
    assign arm_ok = !abort && arm && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
        end else if (arm_ok) begin
            num_d   = arm_num;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = (arm_num == '0 || arm_num > DEPTH_N) ? DONE : WAIT;
        end else begin
            unique case (state_q)
                WAIT: begin
                    if (hit) begin
                        state_d = ASSERT;
                        if (cnt_q != 16'hffff) cnt_d = cnt_q + 16'd1;
                    end
                end
                ASSERT: begin
                    // A missed deadline advances the sequence exactly like an acknowledge.
                    if (ack || tmo) begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = (idx_d == num_q) ? DONE : WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            int_q   <= (state_d == ASSERT);
        end
    end

`ifdef INT_REQ_GEN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt_q;
    logic          terr_q;

    assign tmo = (state_q == ASSERT) && !ack && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            tcnt_q <= (state_q == ASSERT) ? tcnt_q + TW'(1) : '0;
            if (arm_ok) begin
                terr_q <= 1'b0;
            end else if (tmo && !abort) begin
                terr_q <= 1'b1;
            end
        end
    end

    assign timeout_err = terr_q;
`else
    assign tmo         = 1'b0;
    // No deadline hardware: this folds to a constant 0.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign interrupt = int_q;
    assign busy      = (state_q == WAIT) || (state_q == ASSERT);
    assign done      = (state_q == DONE);
    assign int_count = cnt_q;

endmodule

// File: tb/tb_int_req_gen.sv
// Scoreboard bench: driver advances a sequence-level reference model and queues the expected
// outputs per cycle; a negedge monitor pops and compares against the DUT.
module tb_int_req_gen;

    localparam int          DEPTH = 8;
    localparam int          TO    = 4;
    localparam logic [31:0] ACK   = 32'h0000_7f20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] macroscopic_pc = 32'h0;
    logic [31:0] m_int_addr = 32'h0;
    logic [3:0]  m_int_byteen = 4'h0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = 3'd0;
    logic [31:0] cfg_pc = 32'h0;
    logic        arm = 1'b0;
    logic [3:0]  arm_num = 4'd0;
    logic        abort = 1'b0;
    logic        interrupt, busy, done, timeout_err;
    logic [15:0] int_count;

    int_req_gen #(.ACK_ADDR(ACK), .TRIG_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .macroscopic_pc(macroscopic_pc),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
        .arm(arm), .arm_num(arm_num), .abort(abort),
        .interrupt(interrupt), .busy(busy), .done(done),
        .int_count(int_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        irq;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic        terr;
    } obs_t;

    obs_t  exp_q[$];
    string lbl_q[$];
    string phase = "reset";
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    // Reference model: where the sequence is, which entry it is waiting on, and its counters.
    typedef enum int {M_IDLE, M_WAIT, M_FIRE, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    int          m_next = 0;
    int          m_len = 0;
    int          m_fired = 0;
    bit          m_terr = 0;
    int          m_age = 0;
    logic [31:0] m_tab [DEPTH];

    function automatic bit words_equal(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    task automatic model_edge();
        obs_t e;
        bit   advance;
        if (reset) begin
            m_mode = M_IDLE; m_next = 0; m_len = 0; m_fired = 0; m_terr = 0; m_age = 0;
        end else begin
            if (cfg_we && m_mode == M_IDLE) m_tab[cfg_idx] = cfg_pc;
            if (abort) begin
                m_mode = M_IDLE;
            end else if (arm && (m_mode == M_IDLE || m_mode == M_DONE)) begin
                m_len = int'(arm_num); m_next = 0; m_fired = 0; m_terr = 0;
                m_mode = (m_len == 0 || m_len > DEPTH) ? M_DONE : M_WAIT;
            end else if (m_mode == M_WAIT) begin
                if (words_equal(macroscopic_pc, m_tab[m_next])) begin
                    m_mode = M_FIRE; m_age = 0;
                    if (m_fired < 65535) m_fired++;
                end
            end else if (m_mode == M_FIRE) begin
                advance = (m_int_byteen != 0) && words_equal(m_int_addr, ACK);
`ifdef INT_REQ_GEN_TIMEOUT_EN
                if (!advance && m_age + 1 >= TO) begin
                    advance = 1; m_terr = 1;
                end
`endif
                if (advance) begin
                    m_next++;
                    m_mode = (m_next == m_len) ? M_DONE : M_WAIT;
                end else begin
                    m_age++;
                end
            end
        end
        e.irq  = (m_mode == M_FIRE);
        e.busy = (m_mode == M_WAIT || m_mode == M_FIRE);
        e.done = (m_mode == M_DONE);
        e.cnt  = 16'(m_fired);
        e.terr = m_terr;
        exp_q.push_back(e);
        lbl_q.push_back(phase);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
            cyc++;
            arm = 0; abort = 0; cfg_we = 0; m_int_byteen = 4'h0;
        end
    endtask

    task automatic cfg(input int idx, input logic [31:0] pc);
        cfg_we = 1; cfg_idx = 3'(idx); cfg_pc = pc; tick();
    endtask

    task automatic do_arm(input int n);
        arm = 1; arm_num = 4'(n); tick();
    endtask

    task automatic store(input logic [31:0] addr, input logic [3:0] be);
        m_int_addr = addr; m_int_byteen = be; tick();
    endtask

    always @(negedge clk) begin
        obs_t  got, e;
        string l;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            got = {interrupt, busy, done, int_count, timeout_err};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got irq=%0b busy=%0b done=%0b cnt=%0d terr=%0b want irq=%0b busy=%0b done=%0b cnt=%0d terr=%0b",
                         l, cyc, got.irq, got.busy, got.done, got.cnt, got.terr,
                         e.irq, e.busy, e.done, e.cnt, e.terr);
            end
        end
    end

    logic [31:0] pool [8];

    initial begin
        for (int i = 0; i < 8; i++) pool[i] = 32'h3000 + 32'(i * 4);

        phase = "reset"; reset = 1; tick(2); reset = 0;
        phase = "program";
        for (int i = 0; i < DEPTH; i++) cfg(i, 32'h3000 + 32'(i * 8));
        cfg(0, 32'h3012);   // low bits must be dropped

        phase = "basic";
        macroscopic_pc = 32'h2000;
        do_arm(1); tick();
        macroscopic_pc = 32'h3010; tick(3);
        store(32'h7f20, 4'b1111); tick(2);

        phase = "addr_filter";
        macroscopic_pc = 32'h2000;
        do_arm(1); macroscopic_pc = 32'h3010; tick();
        store(32'h7f24, 4'b1111); store(32'h7f20, 4'b0000); tick();
        store(32'h7f22, 4'b0100); tick();

        phase = "multi";
        abort = 1; tick();
        cfg(0, 32'h3008); cfg(1, 32'h3008); cfg(2, 32'h3020);
        macroscopic_pc = 32'h2000;
        do_arm(3); macroscopic_pc = 32'h3008; tick(2);
        store(32'h7f20, 4'b0001); tick(2);
        store(32'h7f20, 4'b1000); tick(2);
        macroscopic_pc = 32'h3020; tick(2);
        store(32'h7f20, 4'b0010); tick(2);

        phase = "cfg_in_wait";
        macroscopic_pc = 32'h2000;
        do_arm(1);
        cfg(0, 32'h3100); arm = 1; arm_num = 4'd5; tick();
        macroscopic_pc = 32'h3100; tick(2);
        macroscopic_pc = 32'h3008; tick(2);
        phase = "no_ack_hold"; tick(10);
        store(32'h7f20, 4'b1111);

        phase = "abort";
        macroscopic_pc = 32'h2000;
        do_arm(3); macroscopic_pc = 32'h3008; tick(2);
        abort = 1; tick(2);
        cfg(0, 32'h3040); macroscopic_pc = 32'h2000;
        do_arm(2); macroscopic_pc = 32'h3040; tick(2);
        store(32'h7f20, 4'b1111); tick();

        phase = "guard_num";
        abort = 1; tick();
        do_arm(0); tick(2);
        do_arm(9); tick(2);
        do_arm(8); tick();

        phase = "reset_in_assert";
        abort = 1; tick();
        do_arm(1); macroscopic_pc = 32'h3040; tick(2);
        reset = 1; tick(); reset = 0; tick(2);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            macroscopic_pc = ($urandom_range(0, 9) < 8) ? (pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)))
                                                       : 32'h2000;
            if ($urandom_range(0, 99) < 25) begin
                m_int_addr   = ($urandom_range(0, 3) != 0) ? (ACK | 32'($urandom_range(0, 3))) : 32'h7f24;
                m_int_byteen = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) < 6) begin
                arm = 1; arm_num = 4'($urandom_range(0, 10));
            end
            if ($urandom_range(0, 99) < 2) abort = 1;
            if ($urandom_range(0, 99) < 6) begin
                cfg_we = 1; cfg_idx = 3'($urandom_range(0, 7)); cfg_pc = pool[$urandom_range(0, 7)];
            end
            reset = ($urandom_range(0, 999) < 4);
            tick();
        end
        reset = 0;
        tick(2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_req_gen.md
# int_req_gen

Synthesizable external-interrupt source for the P7 CPU. It watches the CPU's macroscopic PC and raises `interrupt` when the PC reaches programmed trigger addresses. It drops the request when the CPU acknowledges it by storing to the interrupt-acknowledge address. It is the device-side end of the CPU's `interrupt` / `m_int_addr` / `m_int_byteen` handshake, and it lets directed interrupt scenarios run on the FPGA build without a behavioural stimulus driver.

## Interface
- `ACK_ADDR`, 32'h0000_7f20: word address whose store acknowledges the interrupt.
- `TRIG_DEPTH`, 8: number of trigger-PC entries (power of two, ≥ 2).
- `TIMEOUT_CYCLES`, 1024: acknowledge deadline in cycles. Used only with `INT_REQ_GEN_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `macroscopic_pc` in 32: CPU macroscopic PC. Bits [1:0] are ignored.
- `m_int_addr` in 32: CPU store address. Bits [1:0] are ignored.
- `m_int_byteen` in 4: CPU store byte enables. Any set bit means a store.
- `cfg_we` in 1: write `cfg_pc` into entry `cfg_idx`.
- `cfg_idx` in $clog2(TRIG_DEPTH): trigger entry index.
- `cfg_pc` in 32: trigger PC. Bits [1:0] are dropped on write.
- `arm` in 1: start sequence. Single-cycle pulse.
- `arm_num` in $clog2(TRIG_DEPTH)+1: number of entries to use. Sampled on `arm`.
- `abort` in 1: return to IDLE immediately.
- `interrupt` out 1: interrupt request to the CPU. Registered.
- `busy` out 1: state is WAIT or ASSERT.
- `done` out 1: state is DONE.
- `int_count` out 16: interrupts raised since the last `arm`. Saturates at 16'hFFFF.
- `timeout_err` out 1: sticky flag; the acknowledge deadline was missed.

## Operation
- States:
  - IDLE: the only state in which `cfg_we` is honoured.
  - WAIT: waiting for the PC to match entry `idx`.
  - ASSERT: `interrupt` = 1.
  - DONE: all entries consumed.
- Match condition: state is WAIT and `{macroscopic_pc[31:2],2'b00} == trig[idx]`.
- Acknowledge condition: `|m_int_byteen` and `{m_int_addr[31:2],2'b00} == ACK_ADDR`.
- IDLE, on `arm`:
  - latch `num = arm_num`, set `idx = 0`, clear `int_count`.
  - go to WAIT; go to DONE instead if `arm_num == 0` or `arm_num > TRIG_DEPTH`.
- WAIT, on match: go to ASSERT; `int_count` += 1 (saturating).
- ASSERT, on acknowledge: `idx` += 1; go to DONE if the new `idx == num`, otherwise WAIT.
- An acknowledge seen outside ASSERT is ignored.
- DONE, on `arm`: behaves as `arm` from IDLE.
- Any state, on `abort`: go to IDLE, `interrupt` = 0; `idx` and `int_count` are held.
- Priority order: `reset` > `abort` > `arm` > state transitions.
- `arm`, `cfg_we` and `arm_num` are ignored in WAIT and ASSERT.
- A PC that matches again while ASSERT is held has no effect. Each entry fires once.
- Duplicate PCs in consecutive entries fire consecutively. The second can fire no earlier than one cycle after the first is acknowledged.
- Reset values:
  - outputs: `interrupt` = 0, `busy` = 0, `done` = 0, `int_count` = 0, `timeout_err` = 0.
  - internal: state = IDLE, `idx` = 0, `num` = 0.
- The trigger table is not cleared by reset.

## Timing
- Match sampled at edge N: `interrupt` = 1 from edge N through the acknowledge edge.
- Acknowledge sampled at edge M: `interrupt` = 0 after edge M.
- Next match is evaluated from edge M+1.
- `arm` at edge A: earliest match is at edge A+1.
- `cfg_we` at edge C: the entry is visible to a match at edge C+1.
- `busy`, `done` and `int_count` update on the same edge as the state change.
- `reset` or `abort` while ASSERT: `interrupt` = 0 after that edge. No acknowledge is needed.

## Configuration
- Macro `INT_REQ_GEN_TIMEOUT_EN`, defined:
  - a counter clears on entry to ASSERT and increments each cycle in ASSERT.
  - when the counter reaches `TIMEOUT_CYCLES` with no acknowledge: `timeout_err` is set and the block advances exactly as if acknowledged.
  - `timeout_err` clears only on `reset` or `arm`.
- Macro undefined:
  - no counter is built.
  - `timeout_err` is tied to 0.
  - ASSERT is held indefinitely until acknowledge, `abort` or `reset`.

## Structure
- Package `int_req_gen_pkg` holds:
  - the state enum: IDLE, WAIT, ASSERT, DONE.
  - `ACK_ADDR_DEFAULT` = 32'h0000_7f20.
  - `WORD_MASK` = 32'hffff_fffc.
- Sub-module `int_trig_table`:
  - TRIG_DEPTH×30-bit register file.
  - synchronous write port, combinational read at `idx`.
  - outputs the PC-match comparison.
- Top level holds the FSM, `idx`, `num`, `int_count` and the timeout counter.

## Test plan
- Basic fire and acknowledge:
  - stimulus: entry0 = 0x3010, arm num=1, PC steps to 0x3010.
  - response: `interrupt` rises the following edge.
  - then: store byteen 4'b1111 to 0x7f20 → `interrupt` falls, `done` = 1, `int_count` = 1.
- Address filtering:
  - stimulus: store to 0x7f24, then store to 0x7f22 with byteen 4'b0100.
  - response: the 0x7f24 store leaves `interrupt` at 1; the 0x7f22 store acknowledges (bits [1:0] ignored).
- Multiple entries:
  - stimulus: entries 0x3008, 0x3008, 0x3020, num=3.
  - response: three separate assertions; the second is raised one cycle after the first acknowledge; `int_count` = 3, then DONE.
- Abort mid-sequence:
  - stimulus: `abort` during ASSERT.
  - response: `interrupt` = 0 next edge, state IDLE.
  - then: `cfg_we` now accepted; re-arm clears `int_count`.
- Timeout (macro on, `TIMEOUT_CYCLES` = 4):
  - stimulus: no acknowledge.
  - response: `interrupt` drops after 4 cycles, `timeout_err` = 1, sequence advances.
- Guard cases:
  - stimulus: `arm_num` = 0.
  - response: DONE immediately, no interrupt.
  - stimulus: `reset` while ASSERT.
  - response: all outputs return to their reset values.
